// File: rtl/dbg_pkg.sv
// Shared types and constants for the debug register-dump transmitter.
package dbg_pkg;

    localparam int UART_FRAME_BITS = 10;
    localparam int BYTES_PER_REC   = 5;

    // ST_NEXT is kept for readability of the state list; the view advance
    // happens on the final stop-bit edge, so the FSM never rests in it.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SEND,
        ST_NEXT,
        ST_FINISH
    } state_t;

    // Big-endian byte n (1..4) of a captured register value.
    function automatic logic [7:0] rec_byte(input logic [31:0] word, input logic [2:0] n);
        case (n)
            3'd1:    rec_byte = word[31:24];
            3'd2:    rec_byte = word[23:16];
            3'd3:    rec_byte = word[15:8];
            default: rec_byte = word[7:0];
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// UART 8N1 byte transmitter; ready also rises in the last stop-bit cycle so
// consecutive bytes leave with no idle gap.
module uart_tx_byte import dbg_pkg::*; #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx
);

    localparam int              CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]      BIT_LAST = 4'(UART_FRAME_BITS - 1);

    logic          active_reg;
    logic [CW-1:0] clk_cnt_reg;
    logic [3:0]    bit_idx_reg;
    logic [7:0]    shift_reg;
    logic          tx_reg;
    logic          bit_end;
    logic          frame_end;

    assign bit_end   = active_reg && (clk_cnt_reg == CNT_LAST);
    assign frame_end = bit_end && (bit_idx_reg == BIT_LAST);
    assign ready     = !active_reg || frame_end;
    assign tx        = tx_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            active_reg  <= 1'b0;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
        end else if (valid && ready) begin
            active_reg  <= 1'b1;
            clk_cnt_reg <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= data;
            tx_reg      <= 1'b0;
        end else if (frame_end) begin
            active_reg  <= 1'b0;
            clk_cnt_reg <= '0;
            tx_reg      <= 1'b1;
        end else if (bit_end) begin
            clk_cnt_reg <= '0;
            bit_idx_reg <= bit_idx_reg + 4'd1;
            // after data bit 7 the line goes to the stop level
            if (bit_idx_reg == BIT_LAST - 4'd1) begin
                tx_reg <= 1'b1;
            end else begin
                tx_reg    <= shift_reg[0];
                shift_reg <= {1'b0, shift_reg[7:1]};
            end
        end else if (active_reg) begin
            clk_cnt_reg <= clk_cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/reg_dump_tx.sv
// Walks the core's register-view port and streams each register as a
// 5-byte UART record: index, then the 32-bit value big-endian.
module reg_dump_tx import dbg_pkg::*; #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_REGS     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  view,
    input  logic [31:0] reg_val,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_VIEW = 5'(NUM_REGS - 1);
    localparam logic [2:0] LAST_BYTE = 3'(BYTES_PER_REC - 1);

    state_t      state_reg, state_next;
    logic [2:0]  byte_cnt_reg, byte_cnt_next;
    logic [4:0]  view_reg, view_next;
    logic [31:0] word_q;
    logic [4:0]  idx_q;
    logic        capture;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart (
        .clk   (clk),
        .rst   (rst),
        .valid (tx_valid),
        .data  (tx_data),
        .ready (tx_ready),
        .tx    (tx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= ST_IDLE;
            byte_cnt_reg <= '0;
            view_reg     <= '0;
            word_q       <= '0;
            idx_q        <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            view_reg     <= view_next;
            if (capture) begin
                word_q <= reg_val;
                idx_q  <= view_reg;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        view_next     = view_reg;
        capture       = 1'b0;
        tx_valid      = 1'b0;
        tx_data       = 8'h00;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SETTLE;
                    view_next  = '0;
                end
            end
            ST_SETTLE: begin
                // the index byte leaves on the same edge that captures the value
                tx_valid = 1'b1;
                tx_data  = {3'b000, view_reg};
                if (tx_ready) begin
                    capture       = 1'b1;
                    byte_cnt_next = '0;
                    state_next    = ST_SEND;
                end
            end
            ST_SEND: begin
                if (tx_ready) begin
                    if (byte_cnt_reg != LAST_BYTE) begin
                        byte_cnt_next = byte_cnt_reg + 3'd1;
                        tx_valid      = 1'b1;
                        tx_data       = rec_byte(word_q, byte_cnt_next);
                    end else if (idx_q < LAST_VIEW) begin
                        view_next  = idx_q + 5'd1;
                        state_next = ST_SETTLE;
                    end else begin
                        state_next = ST_FINISH;
                    end
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign view = view_reg;
    assign busy = (state_reg == ST_SETTLE) || (state_reg == ST_SEND);
    assign done = (state_reg == ST_FINISH);

endmodule

// File: tb/tb_reg_dump_tx.sv
// Bench for reg_dump_tx: two instances (2 and 32 registers) driven from
// random register files, line traces compared against framed-byte models.
`timescale 1ns/1ps
module tb_reg_dump_tx;

    localparam int CPB0 = 4;
    localparam int NR0  = 2;
    localparam int CPB1 = 5;
    localparam int NR1  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]        rst_n;
    logic [1:0]        start;
    logic [1:0]        tx;
    logic [1:0]        busy;
    logic [1:0]        done;
    logic [1:0][4:0]   view;
    logic [1:0][31:0]  reg_val;
    logic [31:0]       rf [2][32];

    int total = 0;
    int bad   = 0;

    assign reg_val[0] = rf[0][view[0]];
    assign reg_val[1] = rf[1][view[1]];

    reg_dump_tx #(.CLKS_PER_BIT(CPB0), .NUM_REGS(NR0)) u_small (
        .clk(clk), .rst(rst_n[0]), .start(start[0]), .view(view[0]),
        .reg_val(reg_val[0]), .tx(tx[0]), .busy(busy[0]), .done(done[0])
    );

    reg_dump_tx #(.CLKS_PER_BIT(CPB1), .NUM_REGS(NR1)) u_big (
        .clk(clk), .rst(rst_n[1]), .start(start[1]), .view(view[1]),
        .reg_val(reg_val[1]), .tx(tx[1]), .busy(busy[1]), .done(done[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    // mode 0: view?DEADBEEF:0, mode 1: 0x10000000+view, otherwise random
    task automatic fill_rf(input int u, input int mode);
        for (int k = 0; k < 32; k++) begin
            if (mode == 0)      rf[u][k] = (k != 0) ? 32'hDEADBEEF : 32'h0;
            else if (mode == 1) rf[u][k] = 32'h1000_0000 + 32'(k);
            else                rf[u][k] = $urandom;
        end
    endtask

    task automatic pulse_reset(input int u, input string tag);
        rst_n[u] = 1'b0;
        #1;
        check({tag, "_tx"},   32'(tx[u]),   32'd1);
        check({tag, "_busy"}, 32'(busy[u]), 32'd0);
        check({tag, "_done"}, 32'(done[u]), 32'd0);
        check({tag, "_view"}, 32'(view[u]), 32'd0);
        @(negedge clk);
        rst_n[u] = 1'b1;
    endtask

    task automatic run_dump(input int u, input int mode, input bit repulse, input bit hold);
        int cpb, nr, len, budget;
        int txq[$];
        int busyq[$];
        int doneq[$];
        int viewq[$];
        int expw[$];
        logic [7:0] expb[$];
        logic [7:0] gotb[$];
        int first_idle, busy_ones, done_cnt, done_at, wave_err, view_err, frame_err;
        int s, mid, nb, restart_at, run, p;
        logic [7:0] v;

        cpb    = (u == 0) ? CPB0 : CPB1;
        nr     = (u == 0) ? NR0  : NR1;
        len    = nr * (1 + 50 * cpb);
        budget = len + 40;
        fill_rf(u, mode);

        // reference: record bytes, then the ideal line level per cycle
        for (int r = 0; r < nr; r++) begin
            expb.push_back(8'(r));
            expb.push_back(rf[u][r][31:24]);
            expb.push_back(rf[u][r][23:16]);
            expb.push_back(rf[u][r][15:8]);
            expb.push_back(rf[u][r][7:0]);
        end
        for (int r = 0; r < nr; r++) begin
            expw.push_back(1);
            for (int b = 0; b < 5; b++) begin
                v = expb[5 * r + b];
                for (int bi = 0; bi < 10; bi++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (bi == 0)      expw.push_back(0);
                        else if (bi == 9) expw.push_back(1);
                        else              expw.push_back(int'(v[bi - 1]));
                    end
                end
            end
        end

        @(negedge clk);
        start[u] = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            txq.push_back(int'(tx[u]));
            busyq.push_back(int'(busy[u]));
            doneq.push_back(int'(done[u]));
            viewq.push_back(int'(view[u]));
            start[u] = hold || (repulse && i == 50);
        end
        start[u] = 1'b0;

        first_idle = budget;
        busy_ones  = 0;
        done_cnt   = 0;
        done_at    = -1;
        wave_err   = 0;
        view_err   = 0;
        for (int i = 0; i < budget; i++) begin
            if (busyq[i] == 0 && first_idle == budget) first_idle = i;
            if (busyq[i] == 1) busy_ones++;
        end
        for (int i = 0; i <= len + 1; i++) begin
            if (doneq[i] == 1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        for (int i = 0; i < len; i++) begin
            if (txq[i] != expw[i]) wave_err++;
        end
        for (int i = 1; i <= len; i++) begin
            if (viewq[i] < viewq[i - 1] || viewq[i] > viewq[i - 1] + 1 || viewq[i] >= nr) view_err++;
        end

        check("busy_len", 32'(first_idle), 32'(len));
        if (!hold) check("busy_total", 32'(busy_ones), 32'(len));
        check("done_cnt", 32'(done_cnt), 32'd1);
        check("done_at", 32'(done_at), 32'(len));
        check("view_first", 32'(viewq[0]), 32'd0);
        check("view_seq", 32'(view_err), 32'd0);
        check("view_hold", 32'(viewq[len]), 32'(nr - 1));
        check("wave", 32'(wave_err), 32'd0);

        // independent UART decode of the busy window
        frame_err = 0;
        s = 0;
        while (s < len) begin
            if (txq[s] == 0) begin
                mid = s + cpb / 2;
                if (mid + 9 * cpb >= len) break;
                for (int k = 0; k < 8; k++) v[k] = txq[mid + (k + 1) * cpb][0];
                if (txq[mid] != 0 || txq[mid + 9 * cpb] != 1) frame_err++;
                gotb.push_back(v);
                s = mid + 9 * cpb + 1;
            end else begin
                s++;
            end
        end
        check("frame", 32'(frame_err), 32'd0);
        check("nbytes", 32'(gotb.size()), 32'(5 * nr));
        nb = (gotb.size() < expb.size()) ? gotb.size() : expb.size();
        for (int j = 0; j < nb; j++) begin
            check($sformatf("byte%0d", j), 32'(gotb[j]), 32'(expb[j]));
        end

        // record 1 starts with index byte 0x01: 1 low, 1 high, 7 low bit times
        if (mode == 0) begin
            p = 2 + 50 * cpb;
            run = 0;
            while (p < len && txq[p] == 0) begin run++; p++; end
            check("bit_start", 32'(run), 32'(cpb));
            run = 0;
            while (p < len && txq[p] == 1) begin run++; p++; end
            check("bit_d0", 32'(run), 32'(cpb));
            run = 0;
            while (p < len && txq[p] == 0) begin run++; p++; end
            check("bit_d1_7", 32'(run), 32'(7 * cpb));
        end

        if (hold) begin
            restart_at = budget;
            for (int i = budget - 1; i > len; i--) begin
                if (txq[i] == 0) restart_at = i;
            end
            check("restart_gap", 32'(restart_at - len), 32'd3);
            check("restart_busy", 32'(busyq[len + 2]), 32'd1);
        end

        $display("dump unit=%0d mode=%0d regs=%0d bytes=%0d busy=%0d done_at=%0d",
                 u, mode, nr, gotb.size(), first_idle, done_at);
    endtask

    task automatic reset_mid(input int u);
        int cpb, budget, found, idle_err;
        cpb    = (u == 0) ? CPB0 : CPB1;
        budget = ((u == 0) ? NR0 : NR1) * (1 + 50 * cpb);
        fill_rf(u, 2);
        found = 0;
        @(negedge clk);
        start[u] = 1'b1;
        @(negedge clk);
        start[u] = 1'b0;
        for (int i = 1; i < budget; i++) begin
            @(negedge clk);
            if (i > 1 + 50 * cpb && tx[u] == 1'b0) begin
                found = 1;
                break;
            end
        end
        check("rst_seek", 32'(found), 32'd1);
        check("rst_pre_view", 32'(view[u]), 32'd1);
        pulse_reset(u, "rst_mid");
        idle_err = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx[u] != 1'b1 || busy[u] != 1'b0) idle_err++;
        end
        check("rst_idle", 32'(idle_err), 32'd0);
        $display("reset unit=%0d idle_err=%0d", u, idle_err);
    endtask

    initial begin
        rst_n = 2'b00;
        start = 2'b00;
        for (int u = 0; u < 2; u++) fill_rf(u, 1);
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check($sformatf("reset_tx%0d", u),   32'(tx[u]),   32'd1);
            check($sformatf("reset_busy%0d", u), 32'(busy[u]), 32'd0);
            check($sformatf("reset_done%0d", u), 32'(done[u]), 32'd0);
            check($sformatf("reset_view%0d", u), 32'(view[u]), 32'd0);
        end
        rst_n = 2'b11;
        repeat (2) @(negedge clk);

        run_dump(0, 0, 1'b0, 1'b0);
        run_dump(0, 2, 1'b1, 1'b0);
        run_dump(1, 1, 1'b0, 1'b0);
        run_dump(1, 2, 1'b0, 1'b1);
        pulse_reset(1, "abort");
        reset_mid(0);
        run_dump(0, 2, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
